// File: rtl/edge_implication_monitor_if.sv
// rtl/edge_implication_monitor_if.sv - sample inputs and result outputs of edge_implication_monitor
interface edge_implication_monitor_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic             ant;
  logic             cons;
  logic             pass_pulse;
  logic             fail_pulse;
  logic             vac_pulse;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] vac_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic             first_fail_valid;
  logic [CNT_W-1:0] first_fail_cycle;

  modport master (
    output en, clr, mode, ant, cons,
    input  pass_pulse, fail_pulse, vac_pulse,
    input  pass_cnt, fail_cnt, vac_cnt, cyc_cnt,
    input  first_fail_valid, first_fail_cycle
  );

  modport slave (
    input  en, clr, mode, ant, cons,
    output pass_pulse, fail_pulse, vac_pulse,
    output pass_cnt, fail_cnt, vac_cnt, cyc_cnt,
    output first_fail_valid, first_fail_cycle
  );
endinterface

// File: rtl/edge_implication_monitor.sv
// rtl/edge_implication_monitor.sv - hardware form of ant |-> ##DLY fell/rose/stable/changed(cons)
module edge_implication_monitor #(
  parameter int CNT_W = 16,
  parameter int DLY   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  edge_implication_monitor_if.slave mon
);
  localparam int               PD       = (DLY > 0) ? DLY : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             cons_prev;
  logic [CNT_W-1:0] cyc_q;
  logic             cons_ok;

  // attempt arriving at the end of the pipe on this sample
  logic             end_v;
  logic             end_a;
  logic [CNT_W-1:0] end_c;

  logic             res_pass;
  logic             res_fail;
  logic             res_vac;
  logic [CNT_W-1:0] res_start;

  logic             pass_q;
  logic             fail_q;
  logic             vac_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [CNT_W-1:0] vac_cnt_q;
  logic             ff_valid_q;
  logic [CNT_W-1:0] ff_cycle_q;

  generate
    if (DLY == 0) begin : g_nodly
      assign end_v = 1'b1;
      assign end_a = mon.ant;
      assign end_c = cyc_q;
    end else begin : g_dly
      logic [PD-1:0]    pipe_v;
      logic [PD-1:0]    pipe_a;
      logic [CNT_W-1:0] pipe_c [PD];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_v <= '0;
          pipe_a <= '0;
          for (int i = 0; i < PD; i++) pipe_c[i] <= '0;
        end else if (mon.clr) begin
          pipe_v <= '0;
          pipe_a <= '0;
          for (int i = 0; i < PD; i++) pipe_c[i] <= '0;
        end else if (mon.en) begin
          for (int i = PD - 1; i > 0; i--) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
            pipe_c[i] <= pipe_c[i-1];
          end
          pipe_v[0] <= 1'b1;
          pipe_a[0] <= mon.ant;
          pipe_c[0] <= cyc_q;
        end
      end

      assign end_v = pipe_v[PD-1];
      assign end_a = pipe_a[PD-1];
      assign end_c = pipe_c[PD-1];
    end
  endgenerate

  // consequent compares the live cons against the previous sampled cons
  always_comb begin
    cons_ok = 1'b0;
    unique case (mon.mode)
      2'b00:   cons_ok = cons_prev & ~mon.cons;
      2'b01:   cons_ok = ~cons_prev & mon.cons;
      2'b10:   cons_ok = (cons_prev == mon.cons);
      default: cons_ok = (cons_prev != mon.cons);
    endcase
  end

  // resolution stage: loaded only on samples, consumed on the following edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cons_prev <= 1'b0;
      cyc_q     <= '0;
      res_pass  <= 1'b0;
      res_fail  <= 1'b0;
      res_vac   <= 1'b0;
      res_start <= '0;
    end else if (mon.clr) begin
      cons_prev <= 1'b0;
      cyc_q     <= '0;
      res_pass  <= 1'b0;
      res_fail  <= 1'b0;
      res_vac   <= 1'b0;
      res_start <= '0;
    end else if (mon.en) begin
      cons_prev <= mon.cons;
      if (cyc_q != CNT_MAX) cyc_q <= cyc_q + CNT_ONE;
      res_pass  <= end_v & end_a & cons_ok;
      res_fail  <= end_v & end_a & ~cons_ok;
      res_vac   <= end_v & ~end_a;
      res_start <= end_c;
    end else begin
      res_pass  <= 1'b0;
      res_fail  <= 1'b0;
      res_vac   <= 1'b0;
    end
  end

  // output stage: pulses, saturating counters and first-failure capture move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      vac_q      <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      vac_cnt_q  <= '0;
      ff_valid_q <= 1'b0;
      ff_cycle_q <= '0;
    end else if (mon.clr) begin
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      vac_q      <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      vac_cnt_q  <= '0;
      ff_valid_q <= 1'b0;
      ff_cycle_q <= '0;
    end else begin
      pass_q <= res_pass;
      fail_q <= res_fail;
      vac_q  <= res_vac;
      if (res_pass && pass_cnt_q != CNT_MAX) pass_cnt_q <= pass_cnt_q + CNT_ONE;
      if (res_fail && fail_cnt_q != CNT_MAX) fail_cnt_q <= fail_cnt_q + CNT_ONE;
      if (res_vac && vac_cnt_q != CNT_MAX) vac_cnt_q <= vac_cnt_q + CNT_ONE;
      if (res_fail && !ff_valid_q) begin
        ff_valid_q <= 1'b1;
        ff_cycle_q <= res_start;
      end
    end
  end

  assign mon.pass_pulse       = pass_q;
  assign mon.fail_pulse       = fail_q;
  assign mon.vac_pulse        = vac_q;
  assign mon.pass_cnt         = pass_cnt_q;
  assign mon.fail_cnt         = fail_cnt_q;
  assign mon.vac_cnt          = vac_cnt_q;
  assign mon.cyc_cnt          = cyc_q;
  assign mon.first_fail_valid = ff_valid_q;
  assign mon.first_fail_cycle = ff_cycle_q;
endmodule

// File: tb/tb_edge_implication_monitor.sv
// tb/tb_edge_implication_monitor.sv - three monitor instances (DLY 0/2/3) against a queue-based model
module tb_edge_implication_monitor;
  typedef struct packed {
    logic        pp, fp, vp;
    logic [15:0] pc, fc, vc, cyc;
    logic        ffv;
    logic [15:0] ffc;
  } obs_t;

  typedef struct {
    bit          a;
    bit          c;
    int unsigned idx;
  } smp_t;

  typedef struct {
    bit       a;
    bit       c;
    bit [2:0] exp;
  } vec_t;

  localparam bit [2:0] PN = 3'b000, PP = 3'b100, PF = 3'b010, PV = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0, clr = 1'b0, ant = 1'b0, cons = 1'b0;
  logic [1:0] mode = 2'b00;

  int n_checks = 0;
  int n_fail = 0;

  edge_implication_monitor_if #(.CNT_W(16)) ifa ();
  edge_implication_monitor_if #(.CNT_W(16)) ifb ();
  edge_implication_monitor_if #(.CNT_W(4))  ifc ();

  assign ifa.en = en;  assign ifa.clr = clr;  assign ifa.mode = mode;  assign ifa.ant = ant;  assign ifa.cons = cons;
  assign ifb.en = en;  assign ifb.clr = clr;  assign ifb.mode = mode;  assign ifb.ant = ant;  assign ifb.cons = cons;
  assign ifc.en = en;  assign ifc.clr = clr;  assign ifc.mode = mode;  assign ifc.ant = ant;  assign ifc.cons = cons;

  edge_implication_monitor #(.CNT_W(16), .DLY(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .mon(ifa));
  edge_implication_monitor #(.CNT_W(16), .DLY(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .mon(ifb));
  edge_implication_monitor #(.CNT_W(4),  .DLY(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .mon(ifc));

  always #5 clk = ~clk;

  obs_t act [3];
  always_comb begin
    act[0] = {ifa.pass_pulse, ifa.fail_pulse, ifa.vac_pulse, ifa.pass_cnt, ifa.fail_cnt, ifa.vac_cnt,
              ifa.cyc_cnt, ifa.first_fail_valid, ifa.first_fail_cycle};
    act[1] = {ifb.pass_pulse, ifb.fail_pulse, ifb.vac_pulse, ifb.pass_cnt, ifb.fail_cnt, ifb.vac_cnt,
              ifb.cyc_cnt, ifb.first_fail_valid, ifb.first_fail_cycle};
    act[2] = {ifc.pass_pulse, ifc.fail_pulse, ifc.vac_pulse, 12'd0, ifc.pass_cnt, 12'd0, ifc.fail_cnt,
              12'd0, ifc.vac_cnt, 12'd0, ifc.cyc_cnt, ifc.first_fail_valid, 12'd0, ifc.first_fail_cycle};
  end

  // reference model: sample history since the last clear plus one pending result per instance
  int          dly_of [3] = '{0, 2, 3};
  int unsigned max_of [3] = '{65535, 65535, 15};
  obs_t        exp_o [3];
  bit [2:0]    pend [3];
  int unsigned pend_start [3];
  smp_t        hist [$];
  int unsigned nsamp;

  function automatic int unsigned umin(input int unsigned x, input int unsigned y);
    return (x < y) ? x : y;
  endfunction

  function automatic bit [2:0] pcode(input int d);
    return {act[d].pp, act[d].fp, act[d].vp};
  endfunction

  task automatic model_reset();
    hist.delete();
    nsamp = 0;
    for (int d = 0; d < 3; d++) begin
      exp_o[d] = '0;
      pend[d] = 3'b000;
      pend_start[d] = 0;
    end
  endtask

  task automatic model_edge(input bit e, input bit c, input bit [1:0] m, input bit a, input bit cs);
    smp_t st;
    bit   prev, ok;
    for (int d = 0; d < 3; d++) begin
      if (c) begin
        exp_o[d] = '0;
      end else begin
        {exp_o[d].pp, exp_o[d].fp, exp_o[d].vp} = pend[d];
        if (pend[d][2]) exp_o[d].pc = 16'(umin(32'(exp_o[d].pc) + 1, max_of[d]));
        if (pend[d][1]) exp_o[d].fc = 16'(umin(32'(exp_o[d].fc) + 1, max_of[d]));
        if (pend[d][0]) exp_o[d].vc = 16'(umin(32'(exp_o[d].vc) + 1, max_of[d]));
        if (pend[d][1] && !exp_o[d].ffv) begin
          exp_o[d].ffv = 1'b1;
          exp_o[d].ffc = 16'(pend_start[d]);
        end
      end
      pend[d] = 3'b000;
    end
    if (c) begin
      hist.delete();
      nsamp = 0;
    end else if (e) begin
      st.a = a;
      st.c = cs;
      st.idx = nsamp;
      hist.push_back(st);
      nsamp++;
      prev = (nsamp >= 2) ? hist[hist.size() - 2].c : 1'b0;
      case (m)
        2'b00:   ok = prev && !cs;
        2'b01:   ok = !prev && cs;
        2'b10:   ok = (prev == cs);
        default: ok = (prev != cs);
      endcase
      for (int d = 0; d < 3; d++) begin
        if (nsamp > 32'(dly_of[d])) begin
          st = hist[hist.size() - 1 - dly_of[d]];
          pend[d] = !st.a ? PV : (ok ? PP : PF);
          pend_start[d] = umin(st.idx, max_of[d]);
        end
      end
      if (hist.size() > 8) void'(hist.pop_front());
    end
    for (int d = 0; d < 3; d++) exp_o[d].cyc = 16'(umin(nsamp, max_of[d]));
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic step(input bit e, input bit c, input bit [1:0] m, input bit a, input bit cs);
    en = e; clr = c; mode = m; ant = a; cons = cs;
    @(posedge clk);
    #1;
    model_edge(e, c, m, a, cs);
    for (int d = 0; d < 3; d++) check($sformatf("model_dut%0d", d), 128'(act[d]), 128'(exp_o[d]));
  endtask

  task automatic run_rose(input int gap);
    bit [0:5] ra   = 6'b100000;
    bit [0:5] rc   = 6'b000100;
    bit [2:0] rexp [7] = '{PN, PN, PN, PF, PV, PV, PV};
    int       s = 0;
    bit       smp;
    step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    for (int t = 0; t < 7 + gap; t++) begin
      smp = !(t >= 2 && t < 2 + gap) && (s < 6);
      step(smp, 1'b0, 2'b01, smp ? ra[s] : 1'b0, smp ? rc[s] : 1'b0);
      if (smp) s++;
      check($sformatf("rose_gap%0d_t%0d", gap, t), 128'(pcode(1)), 128'((t < 2 + gap) ? PN : rexp[t - gap]));
    end
    check($sformatf("rose_gap%0d_cyc", gap), 128'(act[1].cyc), 128'(6));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t     tbl [8];
    bit [2:0] mexp [8];
    tbl[0] = '{1'b0, 1'b1, PV}; tbl[1] = '{1'b1, 1'b0, PP};
    tbl[2] = '{1'b1, 1'b1, PF}; tbl[3] = '{1'b0, 1'b0, PV};
    tbl[4] = '{1'b1, 1'b1, PF}; tbl[5] = '{1'b1, 1'b1, PF};
    tbl[6] = '{1'b1, 1'b1, PF}; tbl[7] = '{1'b1, 1'b1, PF};
    mexp = '{PF, PP, PF, PP, PP, PP, PP, PP};

    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check($sformatf("reset_dut%0d", d), 128'(act[d]), 128'(0));
    @(negedge clk) rst_n = 1'b1;

    // fell, DLY=0: pulse for vector i is visible after edge i+1
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 2'b00, tbl[i].a, tbl[i].c);
      if (i > 0) check($sformatf("fell_pulse%0d", i - 1), 128'(pcode(0)), 128'(tbl[i-1].exp));
    end
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    check("fell_pulse7", 128'(pcode(0)), 128'(tbl[7].exp));
    check("fell_pass_cnt", 128'(act[0].pc), 128'(1));
    check("fell_fail_cnt", 128'(act[0].fc), 128'(5));
    check("fell_vac_cnt", 128'(act[0].vc), 128'(2));
    check("fell_cyc_cnt", 128'(act[0].cyc), 128'(8));
    check("fell_ff_cycle", 128'({act[0].ffv, act[0].ffc}), 128'({1'b1, 16'd2}));

    run_rose(0);
    run_rose(3);

    // saturation on the 4-bit instance
    step(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 2'b10, 1'b1, 1'b1);
    step(1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    check("sat_pass_cnt", 128'(act[2].pc), 128'(15));
    check("sat_cyc_cnt", 128'(act[2].cyc), 128'(15));
    check("sat_pulse", 128'(pcode(2)), 128'(PP));
    check("sat_fail_cnt", 128'(act[2].fc), 128'(0));

    // clear mid-run: cons_prev must restart at 0
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    step(1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    check("clr_all_zero", 128'(act[0]), 128'(0));
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    check("clr_prev_zero", 128'(pcode(0)), 128'(PF));

    // mode switch fell -> changed between samples 3 and 4
    step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, (i < 4) ? 2'b00 : 2'b11, 1'b1, (i % 2) == 0);
      if (i > 0) check($sformatf("mode_pulse%0d", i - 1), 128'(pcode(0)), 128'(mexp[i-1]));
    end
    step(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    check("mode_pulse7", 128'(pcode(0)), 128'(mexp[7]));

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // async reset between edges, no clock needed
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) check($sformatf("async_rst_dut%0d", d), 128'(act[d]), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'b01, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
